// File: rtl/sipo_load_if.sv
// Host-to-sequencer load handshake for the table shift register.
// One parallel table word moves per valid/ready transfer.
interface sipo_load_if #(
  parameter int DATA_W = 25
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/sipo_load_ctrl.sv
// Load sequencer for the table SIPO: clear, shift marker+data, then
// watch the finished flag and report done or error.
module sipo_load_ctrl #(
  parameter int DATA_W    = 25,
  parameter int CLR_CYC   = 2,
  parameter int FIN_SLACK = 4
) (
  input  logic       clock,
  input  logic       rst,
  sipo_load_if.slave load,
  input  logic       abort,
  output logic       sipo_in,
  output logic       sipo_en,
  output logic       sipo_clr,
  input  logic       sipo_fin,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] bit_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    WAIT_FIN,
    DONE
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'(DATA_W);
  localparam logic [3:0] CLR_LAST = 4'(CLR_CYC - 1);
  localparam logic [3:0] FIN_LAST = 4'(FIN_SLACK - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] shreg;
  logic              ready_q;
  logic              accept;
  logic              in_load;
  logic              abort_hit;
  logic              early;

  assign load.ready = ready_q;
  assign accept     = load.valid & ready_q;

  always_comb begin
    in_load = 1'b0;
    unique case (1'b1)
      state == CLEAR:    in_load = 1'b1;
      state == SHIFT:    in_load = 1'b1;
      state == WAIT_FIN: in_load = 1'b1;
      default:           in_load = 1'b0;
    endcase
  end

  assign abort_hit = abort & in_load;
  // fin during the final enabled cycle is the normal arrival edge
  assign early     = sipo_fin & (bit_cnt != LAST_BIT);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      ready_q  <= 1'b1;
      sipo_in  <= 1'b0;
      sipo_en  <= 1'b0;
      sipo_clr <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (sipo_en) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (abort_hit) begin
        // leave the chain cleared so a half frame never looks valid
        state    <= IDLE;
        ready_q  <= 1'b1;
        busy     <= 1'b0;
        sipo_en  <= 1'b0;
        sipo_in  <= 1'b0;
        sipo_clr <= 1'b1;
        shreg    <= '0;
        cnt      <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            sipo_clr <= 1'b0;
            if (accept) begin
              state    <= CLEAR;
              shreg    <= load.data;
              err      <= 1'b0;
              bit_cnt  <= '0;
              cnt      <= '0;
              ready_q  <= 1'b0;
              busy     <= 1'b1;
              sipo_clr <= 1'b1;
            end
          end
          CLEAR: begin
            if (cnt == CLR_LAST) begin
              state    <= SHIFT;
              cnt      <= '0;
              sipo_clr <= 1'b0;
              sipo_en  <= 1'b1;
              sipo_in  <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          SHIFT: begin
            if (early) begin
              state   <= IDLE;
              err     <= 1'b1;
              ready_q <= 1'b1;
              busy    <= 1'b0;
              sipo_en <= 1'b0;
              sipo_in <= 1'b0;
            end else if (bit_cnt == LAST_BIT) begin
              state   <= WAIT_FIN;
              cnt     <= '0;
              sipo_en <= 1'b0;
              sipo_in <= 1'b0;
            end else begin
              sipo_in <= shreg[DATA_W-1];
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
            end
          end
          WAIT_FIN: begin
            if (sipo_fin) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (cnt == FIN_LAST) begin
              state   <= IDLE;
              err     <= 1'b1;
              ready_q <= 1'b1;
              busy    <= 1'b0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          DONE: begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy    <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
